// File: rtl/scan_mem_arbiter_if.sv
// Shared-memory read port bundle between two requesters, the arbiter and memory.
// slave  : arbiter side (takes requests and memory data, drives grants and reads)
// master : environment side (requesters plus memory)
interface scan_mem_arbiter_if #(
  parameter int DW = 9
);
  logic          REQ0;
  logic [4:0]    ADDR0;
  logic          LOCK0;
  logic          REQ1;
  logic [4:0]    ADDR1;
  logic [DW-1:0] MEM_RDATA;
  logic          MEM_RD;
  logic [4:0]    MEM_ADDR;
  logic          GNT0;
  logic          GNT1;
  logic          RVALID0;
  logic          RVALID1;
  logic [DW-1:0] RDATA;

  modport slave (
    input  REQ0, ADDR0, LOCK0, REQ1, ADDR1, MEM_RDATA,
    output MEM_RD, MEM_ADDR, GNT0, GNT1, RVALID0, RVALID1, RDATA
  );

  modport master (
    output REQ0, ADDR0, LOCK0, REQ1, ADDR1, MEM_RDATA,
    input  MEM_RD, MEM_ADDR, GNT0, GNT1, RVALID0, RVALID1, RDATA
  );
endinterface

// File: rtl/scan_mem_arbiter.sv
// Two-requester arbiter for a shared single-port memory with 1-cycle read latency.
// Requester 0 (scan engine) may lock the port for bursts of up to MAXBURST reads
// while requester 1 (display refresh) waits; otherwise ties are round-robin.
// The grant state itself is the registered grant: G0/G1 mean "read issued this cycle".
module scan_mem_arbiter #(
  parameter int DW       = 9,
  parameter int MAXBURST = 4
) (
  input  logic                CLOCK,
  input  logic                RESET,
  scan_mem_arbiter_if.slave   bus
);

  localparam int BW = $clog2(MAXBURST + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          last, last_nxt;          // side that won the most recent grant
  logic [BW-1:0] bcnt, bcnt_nxt;          // consecutive GNT0 while REQ1 is waiting
  logic [4:0]    mem_addr_q;
  // read-in-flight pipe: index 0 is the grant cycle, index 1 the data cycle
  logic [1:0]    vld0_pipe, vld1_pipe;

  // state register plus arbitration bookkeeping
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      last  <= 1'b1;
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

  // next-state: pick the winner from the requests sampled at this edge
  always_comb begin
    state_nxt = IDLE;
    if (bus.REQ0 && !bus.REQ1) begin
      state_nxt = G0;
    end else if (bus.REQ1 && !bus.REQ0) begin
      state_nxt = G1;
    end else if (bus.REQ0 && bus.REQ1) begin
      if (bcnt >= BW'(MAXBURST))
        state_nxt = G1;                   // burst exhausted, requester 1 must get in
      else if (bus.LOCK0 && !last)
        state_nxt = G0;                   // locked burst continues only after a GNT0
      else
        state_nxt = last ? G0 : G1;       // plain round-robin
    end
  end

  // LAST follows the winner; BCNT counts GNT0s that made REQ1 wait
  always_comb begin
    last_nxt = last;
    bcnt_nxt = bcnt;
    if (state_nxt == G0) last_nxt = 1'b0;
    if (state_nxt == G1) last_nxt = 1'b1;
    if (state_nxt == G1 || !bus.REQ1)
      bcnt_nxt = '0;
    else if (state_nxt == G0)
      bcnt_nxt = bcnt + 1'b1;
  end

  // memory address: capture the winner's address, hold it otherwise
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET)
      mem_addr_q <= '0;
    else if (state_nxt == G0)
      mem_addr_q <= bus.ADDR0;
    else if (state_nxt == G1)
      mem_addr_q <= bus.ADDR1;
  end

  // read-in-flight tracking; reset drops any outstanding read
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      vld0_pipe[1] <= 1'b0;
      vld1_pipe[1] <= 1'b0;
    end else begin
      vld0_pipe[1] <= vld0_pipe[0];
      vld1_pipe[1] <= vld1_pipe[0];
    end
  end

  // outputs decoded from the grant state and the in-flight pipe
  always_comb begin
    vld0_pipe[0] = (state == G0);
    vld1_pipe[0] = (state == G1);
    bus.GNT0     = vld0_pipe[0];
    bus.GNT1     = vld1_pipe[0];
    bus.MEM_RD   = (state != IDLE);
    bus.MEM_ADDR = mem_addr_q;
    bus.RVALID0  = vld0_pipe[1];
    bus.RVALID1  = vld1_pipe[1];
    bus.RDATA    = (vld0_pipe[1] || vld1_pipe[1]) ? bus.MEM_RDATA : '0;
  end

  // one owner per cycle on both the grant and the return path
  a_gnt_onehot: assert property (@(posedge CLOCK) disable iff (RESET)
    !(bus.GNT0 && bus.GNT1));
  a_rv_onehot: assert property (@(posedge CLOCK) disable iff (RESET)
    !(bus.RVALID0 && bus.RVALID1));

endmodule

// File: tb/tb_scan_mem_arbiter.sv
// Bench for scan_mem_arbiter: directed scenarios then randomized traffic, all
// checked cycle by cycle against a transaction-level arbitration model.
module tb_scan_mem_arbiter;
  localparam int DW = 9;
  localparam int MB = 4;

  logic CLOCK = 1'b0;
  logic RESET;
  always #5 CLOCK = ~CLOCK;

  scan_mem_arbiter_if #(.DW(DW)) bus();
  scan_mem_arbiter #(.DW(DW), .MAXBURST(MB)) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

  // memory with registered read port
  logic [DW-1:0] mem [32];
  always @(posedge CLOCK)
    if (bus.MEM_RD) bus.MEM_RDATA <= mem[bus.MEM_ADDR];

  int total = 0;
  int bad   = 0;

  // reference model: who was granted last, how long REQ1 has waited,
  // and the expected grant/return for the current cycle
  int m_last, m_bcnt;
  int e_g, e_addr, e_rv, e_data;
  int obs;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // arbitration rule: single request wins; a tie goes to requester 1 once it has
  // waited MB grants, stays with a locked requester 0 that won last, else alternates
  function automatic int pick(input bit r0, input bit r1, input bit l0);
    if (!r0 && !r1) return -1;
    if (r0 != r1)   return r0 ? 0 : 1;
    if (m_bcnt == MB) return 1;
    if (l0 && m_last == 0) return 0;
    return 1 - m_last;
  endfunction

  task automatic step();
    bit r0, r1, l0;
    int a0, a1, w;
    r0 = bus.REQ0; r1 = bus.REQ1; l0 = bus.LOCK0;
    a0 = int'(bus.ADDR0); a1 = int'(bus.ADDR1);
    @(posedge CLOCK);
    e_rv   = e_g;
    e_data = (e_g >= 0) ? int'(mem[e_addr]) : 0;
    w = pick(r0, r1, l0);
    if (w == 1 || !r1)  m_bcnt = 0;
    else if (w == 0)    m_bcnt++;
    if (w >= 0) begin
      m_last = w;
      e_addr = (w == 0) ? a0 : a1;
    end
    e_g = w;
    #1;
    obs = bus.GNT0 ? 0 : (bus.GNT1 ? 1 : -1);
    chk("gnt0",    bus.GNT0,    e_g == 0);
    chk("gnt1",    bus.GNT1,    e_g == 1);
    chk("mem_rd",  bus.MEM_RD,  e_g >= 0);
    chk("mem_addr", bus.MEM_ADDR, e_addr);
    chk("rvalid0", bus.RVALID0, e_rv == 0);
    chk("rvalid1", bus.RVALID1, e_rv == 1);
    chk("rdata",   bus.RDATA,   e_data);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"},  {bus.GNT0, bus.GNT1}, 0);
    chk({tag, "_rd"},   bus.MEM_RD, 0);
    chk({tag, "_addr"}, bus.MEM_ADDR, 0);
    chk({tag, "_rv"},   {bus.RVALID0, bus.RVALID1}, 0);
    chk({tag, "_rdata"}, bus.RDATA, 0);
  endtask

  task automatic do_reset();
    #1 RESET = 1'b1;
    m_last = 1; m_bcnt = 0; e_g = -1; e_addr = 0;
    #1 chk_zero("rst");
    repeat (2) begin
      @(posedge CLOCK);
      #1 chk_zero("rst_hold");
    end
    #2 RESET = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.REQ0 = 1'b0; bus.REQ1 = 1'b0; bus.LOCK0 = 1'b0;
  endtask

  initial begin
    RESET = 1'b0;
    idle_inputs();
    bus.ADDR0 = '0; bus.ADDR1 = '0;
    foreach (mem[i]) mem[i] = DW'($urandom);
    mem[5] = 9'h1EA;                     // -22
    do_reset();

    // single read from requester 0, data returned one cycle later
    bus.REQ0 = 1'b1; bus.ADDR0 = 5'd5;
    step();
    chk("t33_gnt0", bus.GNT0, 1);
    chk("t33_addr", bus.MEM_ADDR, 5);
    bus.REQ0 = 1'b0;
    step();
    chk("t33_rv0",   bus.RVALID0, 1);
    chk("t33_rdata", bus.RDATA, 9'h1EA);

    // both requesting, no lock: alternate, starting with 1 since 0 won last
    bus.REQ0 = 1'b1; bus.REQ1 = 1'b1; bus.ADDR0 = 5'd3; bus.ADDR1 = 5'd17;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t34_seq", obs, (i % 2 == 0) ? 1 : 0);
    end
    idle_inputs();
    step();
    step();

    // locked burst: GNT0 x4, GNT1, GNT0 x4, GNT1
    bus.REQ0 = 1'b1; bus.ADDR0 = 5'd9;
    step();
    chk("t35_first", obs, 0);
    bus.REQ1 = 1'b1; bus.LOCK0 = 1'b1; bus.ADDR1 = 5'd30;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t35_seq", obs, (i == 4 || i == 9) ? 1 : 0);
    end
    idle_inputs();
    step();
    step();

    // requester 1 drops its request while requester 0 is being served
    bus.REQ0 = 1'b1; bus.REQ1 = 1'b1; bus.ADDR0 = 5'd1; bus.ADDR1 = 5'd2;
    step();
    chk("t37_gnt0", obs, 0);
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t37_no_gnt", obs, -1);
      chk("t37_no_rv1", bus.RVALID1, 0);
    end

    // back-to-back sweep of all 32 addresses, wrapping
    bus.REQ0 = 1'b1; bus.ADDR0 = 5'd0;
    for (int i = 0; i < 32; i++) begin
      step();
      chk("t38_gnt0", bus.GNT0, 1);
      chk("t38_addr", bus.MEM_ADDR, i);
      bus.ADDR0 = 5'((i + 1) % 32);
    end
    idle_inputs();
    step();
    chk("t38_last_rv", bus.RVALID0, 1);
    step();

    // reset with a requester-1 read in flight
    bus.REQ1 = 1'b1; bus.ADDR1 = 5'd12;
    step();
    chk("t36_gnt1", bus.GNT1, 1);
    idle_inputs();
    do_reset();
    step();
    chk("t36_no_rv1", bus.RVALID1, 0);
    bus.REQ0 = 1'b1; bus.REQ1 = 1'b1; bus.ADDR0 = 5'd7; bus.ADDR1 = 5'd8;
    step();
    chk("t36_tie_gnt0", obs, 0);
    idle_inputs();
    step();

    // randomized traffic with occasional cancels, lock toggles and resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(499) == 0) begin
        idle_inputs();
        do_reset();
      end
      if (bus.REQ0) begin
        if (e_g == 0) begin
          if ($urandom_range(1) == 1) bus.ADDR0 = 5'($urandom);
          else bus.REQ0 = 1'b0;
        end else if ($urandom_range(15) == 0) bus.REQ0 = 1'b0;
      end else if ($urandom_range(1) == 1) begin
        bus.REQ0 = 1'b1; bus.ADDR0 = 5'($urandom);
      end
      if (bus.REQ1) begin
        if (e_g == 1) begin
          if ($urandom_range(2) == 0) bus.ADDR1 = 5'($urandom);
          else bus.REQ1 = 1'b0;
        end else if ($urandom_range(15) == 0) bus.REQ1 = 1'b0;
      end else if ($urandom_range(2) == 0) begin
        bus.REQ1 = 1'b1; bus.ADDR1 = 5'($urandom);
      end
      if ($urandom_range(7) == 0) bus.LOCK0 = ~bus.LOCK0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
